// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: request/response handshake bundle between an initiator and the ALU unit
interface alu_seq_unit_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       select;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic             zeroflag;
  logic             err;
  logic             busy;
  modport master (
    output req_valid, a, b, select, resp_ready,
    input  req_ready, resp_valid, result, zeroflag, err, busy
  );
  modport slave (
    input  req_valid, a, b, select, resp_ready,
    output req_ready, resp_valid, result, zeroflag, err, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU with single-cycle ops, iterative shifts and shift-add multiply
module alu_seq_unit #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          reset,
  alu_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, RESP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             right_q, right_d, zf_q, zf_d, err_q, err_d;
  // next state: res doubles as shift working register and multiply accumulator
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        err_d   = bus.select[3];
        right_d = bus.select[0];
        cnt_d   = bus.b[CW-1:0];
        state_d = RESP;
        case (bus.select)
          4'd0: res_d = bus.a + bus.b;
          4'd1: res_d = bus.a - bus.b;
          4'd2: res_d = bus.a & bus.b;
          4'd3: res_d = bus.a | bus.b;
          4'd4, 4'd5: begin
            res_d   = bus.a;
            state_d = bus.b[CW-1:0] == '0 ? RESP : SHIFT;
          end
          4'd6: res_d = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
          4'd7: begin
            res_d   = '0;
            cnt_d   = '0;
            state_d = MUL;
          end
          default: res_d = '0;
        endcase
      end
      SHIFT: begin
        res_d   = right_q ? res_q >> 1 : res_q << 1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? RESP : SHIFT;
      end
      MUL: begin
        res_d   = b_q[0] ? res_q + a_q : res_q;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? RESP : MUL;
      end
      default: if (bus.resp_ready) begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
    zf_d = state_d == RESP && res_d == '0;
  end
  // state and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      zf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      zf_q    <= zf_d;
      err_q   <= err_d;
    end
  end
  assign bus.req_ready  = state_q == IDLE && !reset;
  assign bus.resp_valid = state_q == RESP;
  assign bus.busy       = state_q != IDLE;
  assign bus.result     = res_q;
  assign bus.zeroflag   = zf_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed self-checking bench for alu_seq_unit
module tb_alu_seq_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  alu_seq_unit_if #(.WIDTH(32)) bus ();
  alu_seq_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [3:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic ez,
                     input logic ee, input int elat);
    int lat;
    @(negedge clk);
    check({tag, ".req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.select    = sel;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.a         = 32'hdead_beef;
    bus.b         = 32'h1234_5678;
    bus.select    = 4'd1;
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".result"}, bus.result, er);
    check({tag, ".zeroflag"}, {31'b0, bus.zeroflag}, {31'b0, ez});
    check({tag, ".err"}, {31'b0, bus.err}, {31'b0, ee});
    @(posedge clk);
    #1;
    check({tag, ".idle_after"}, {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask
  initial begin
    int seen;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    bus.a          = '0;
    bus.b          = '0;
    bus.select     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
    check("rst.busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst.flags", {27'b0, bus.req_ready, bus.resp_valid, bus.zeroflag, bus.err, bus.busy}, 32'b10000);
    check("rst.result", bus.result, 32'd0);
    run("add", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
    run("sub", 4'd1, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    run("and", 4'd2, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run("or",  4'd3, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run("slt", 4'd6, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    run("sll31", 4'd4, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
    run("srl0", 4'd5, 32'h8000_0000, 32'd32, 32'h8000_0000, 1'b0, 1'b0, 1);
    run("srl4", 4'd5, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5);
    run("sll1", 4'd4, 32'd3, 32'd1, 32'd6, 1'b0, 1'b0, 2);
    run("mul_neg", 4'd7, 32'hffff_ffff, 32'd2, 32'hffff_fffe, 1'b0, 1'b0, 33);
    run("mul_ovf", 4'd7, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 33);
    run("mul_small", 4'd7, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33);
    run("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hffff_ffff, 1'b0, 1'b0, 1);
    run("slt_neg", 4'd6, 32'hffff_ffff, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run("undef9", 4'd9, 32'd5, 32'd3, 32'd0, 1'b1, 1'b1, 1);
    run("add_after_err", 4'd0, 32'h7fff_ffff, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.select     = 4'd0;
    bus.a          = 32'd5;
    bus.b          = 32'd7;
    @(posedge clk);
    #1;
    bus.a = 32'd99;
    bus.b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      check("bp.result", bus.result, 32'd12);
      check("bp.valid_ready", {30'b0, bus.resp_valid, bus.req_ready}, 32'b10);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.released", {30'b0, bus.resp_valid, bus.req_ready}, 32'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("bp.next_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("bp.next_result", bus.result, 32'd100);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.select    = 4'd7;
    bus.a         = 32'd3;
    bus.b         = 32'd5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mrst.req_ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mrst.flags", {27'b0, bus.req_ready, bus.resp_valid, bus.zeroflag, bus.err, bus.busy}, 32'b10000);
    check("mrst.result", bus.result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    check("mrst.no_resp", seen, 0);
    run("add_post_rst", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
